data_memory_ctrl: RTL and testbench

- Parametrised, byte-addressed data memory with a request/ready handshake and configurable access latency, for the MEM stage of the pipelined MIPS core.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads, plus alignment and range checking.
- Holds the pipeline via `busy` while an access is in flight.

---
 rtl/data_memory_ctrl.sv | 149 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory for the MEM stage: request/ready handshake,
// configurable latency, byte/half/word accesses with alignment and range checks.
module data_memory_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 1,
  parameter int PRELOAD_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        writeEnable,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  input  logic [31:0] address,
  input  logic [31:0] dataWrite,
  output logic [31:0] dataOutput,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  // state  | meaning
  // IDLE   | waiting for req; request inputs captured on acceptance
  // WAIT   | latency countdown; access performed on the edge leaving WAIT
  // DONE   | ready (and error if rejected) shown for one cycle
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;

  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_err;

  logic [31:0]   mem [DEPTH];

  logic          accept, access;
  logic          misaligned, illegal, out_of_range, reject;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [3:0]    lane_en;
  logic [31:0]   wdata_rep;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req) state_next = S_WAIT;
      S_WAIT:  if (cnt == '0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = (state == S_IDLE) && req;
  assign access = (state == S_WAIT) && (cnt == '0);

  assign misaligned   = ((r_size == 2'b01) && r_addr[0]) ||
                        ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
  assign illegal      = (r_size == 2'b11);
  assign out_of_range = |r_addr[31:AW+2];
  assign reject       = misaligned || illegal || out_of_range;

  assign idx     = r_addr[AW+1:2];
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{r_addr[1:0], 3'b000} +: 8];
  assign rd_half = r_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val  = rd_word;
    lane_en   = 4'b1111;
    wdata_rep = r_wdata;
    case (r_size)
      2'b00: begin
        load_val  = {(r_uns ? 24'h0 : {24{rd_byte[7]}}), rd_byte};
        lane_en   = 4'b0001 << r_addr[1:0];
        wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        load_val  = {(r_uns ? 16'h0 : {16{rd_half[15]}}), rd_half};
        lane_en   = r_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      dataOutput <= '0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      if (accept) begin
        cnt     <= CW'(LATENCY - 1);
        r_we    <= writeEnable;
        r_size  <= size;
        r_uns   <= unsignedLoad;
        r_addr  <= address;
        r_wdata <= dataWrite;
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        r_err <= reject;
        if (!reject && !r_we) dataOutput <= load_val;
      end
    end
  end

  // Reset only touches the boot words; everything else survives reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (PRELOAD_EN != 0) begin
        mem[AW'(32)] <= 32'd2;
        mem[AW'(33)] <= 32'd0;
        mem[AW'(34)] <= 32'd64;
        mem[AW'(35)] <= 32'd4;
      end
    end else if (access && !reject && r_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign busy  = (state != S_IDLE);
  assign ready = (state == S_DONE);
  assign error = ready && r_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: vector table on a LATENCY=1 instance,
// plus hand sequences for held requests (LATENCY=4) and reset abort.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst, req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata, dout;
  logic        ready, busy, error;

  logic        rst4, req4, we4, uns4;
  logic [1:0]  size4;
  logic [31:0] addr4, wdata4, dout4;
  logic        ready4, busy4, error4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH(1024), .LATENCY(1), .PRELOAD_EN(1)) dut (
    .clk(clk), .rst(rst), .req(req), .writeEnable(we), .size(size),
    .unsignedLoad(uns), .address(addr), .dataWrite(wdata),
    .dataOutput(dout), .ready(ready), .busy(busy), .error(error)
  );

  data_memory_ctrl #(.DEPTH(64), .LATENCY(4), .PRELOAD_EN(1)) dut4 (
    .clk(clk), .rst(rst4), .req(req4), .writeEnable(we4), .size(size4),
    .unsignedLoad(uns4), .address(addr4), .dataWrite(wdata4),
    .dataOutput(dout4), .ready(ready4), .busy(busy4), .error(error4)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [29];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic run_access(input logic we_i, input logic [1:0] sz, input logic un,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] got_d, output logic got_e,
                            output logic got_b, output int lat);
    @(negedge clk);
    req = 1'b1; we = we_i; size = sz; uns = un; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (!ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got_d = dout;
    got_e = error;
    got_b = busy;
  endtask

  task automatic access_chk(input string nm, input logic we_i, input logic [1:0] sz,
                            input logic un, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] gd;
    logic        ge, gb;
    int          lat;
    run_access(we_i, sz, un, a, d, gd, ge, gb, lat);
    chk({nm, ".lat"}, 32'(lat), 32'd2);
    chk({nm, ".data"}, gd, exp_d);
    chk({nm, ".err"}, {31'd0, ge}, {31'd0, exp_e});
    chk({nm, ".busy"}, {31'd0, gb}, 32'd1);
  endtask

  initial begin
    int rcount, bcount, first_r, last_r;

    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'd128,       32'h0,        32'd2,        1'b0};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'd132,       32'h0,        32'd0,        1'b0};
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'd136,       32'h0,        32'd64,       1'b0};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'd140,       32'h0,        32'd4,        1'b0};
    vecs[4]  = '{1'b1, 2'b10, 1'b0, 32'h10,        32'hDEADBEEF, 32'd4,        1'b0};
    vecs[5]  = '{1'b1, 2'b00, 1'b0, 32'h11,        32'hAAAAAA7F, 32'd4,        1'b0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h10,        32'h0,        32'hDEAD7FEF, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h13,        32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'h13,        32'h0,        32'h000000DE, 1'b0};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h12,        32'h0,        32'hFFFFDEAD, 1'b0};
    vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h12,        32'h0,        32'h0000DEAD, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h11,        32'h0,        32'h0000007F, 1'b0};
    vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h10,        32'h0,        32'h00007FEF, 1'b0};
    vecs[13] = '{1'b1, 2'b10, 1'b0, 32'h04,        32'h11223344, 32'h00007FEF, 1'b0};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h06,        32'h12345678, 32'h00007FEF, 1'b1};
    vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h04,        32'h0,        32'h11223344, 1'b0};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h1000,      32'h0,        32'h11223344, 1'b1};
    vecs[17] = '{1'b0, 2'b11, 1'b0, 32'h10,        32'h0,        32'h11223344, 1'b1};
    vecs[18] = '{1'b0, 2'b01, 1'b0, 32'h11,        32'h0,        32'h11223344, 1'b1};
    vecs[19] = '{1'b1, 2'b10, 1'b0, 32'h14,        32'h0,        32'h11223344, 1'b0};
    vecs[20] = '{1'b1, 2'b01, 1'b0, 32'h16,        32'h9999BEEF, 32'h11223344, 1'b0};
    vecs[21] = '{1'b0, 2'b10, 1'b0, 32'h14,        32'h0,        32'hBEEF0000, 1'b0};
    vecs[22] = '{1'b1, 2'b00, 1'b0, 32'h14,        32'h12345680, 32'hBEEF0000, 1'b0};
    vecs[23] = '{1'b0, 2'b00, 1'b0, 32'h14,        32'h0,        32'hFFFFFF80, 1'b0};
    vecs[24] = '{1'b0, 2'b10, 1'b0, 32'h14,        32'h0,        32'hBEEF0080, 1'b0};
    vecs[25] = '{1'b1, 2'b10, 1'b0, 32'hFFC,       32'hCAFEF00D, 32'hBEEF0080, 1'b0};
    vecs[26] = '{1'b0, 2'b10, 1'b0, 32'hFFC,       32'h0,        32'hCAFEF00D, 1'b0};
    vecs[27] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFC,  32'h0,        32'hCAFEF00D, 1'b1};
    vecs[28] = '{1'b0, 2'b00, 1'b1, 32'h16,        32'h0,        32'h000000EF, 1'b0};

    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b10; uns = 1'b0; addr = '0; wdata = '0;
    rst4 = 1'b1; req4 = 1'b0; we4 = 1'b0; size4 = 2'b10; uns4 = 1'b0; addr4 = 32'd128; wdata4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst4 = 1'b0;
    chk("reset.dout", dout, 32'h0);
    chk("reset.ready", {31'd0, ready}, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.error", {31'd0, error}, 32'd0);

    for (int i = 0; i < 29; i++) begin
      access_chk($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns,
                 vecs[i].addr, vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_err);
      if (i == 0) begin
        @(negedge clk);
        chk("ready_one_cycle", {31'd0, ready}, 32'd0);
      end
    end

    // Reset during WAIT aborts the store and restores the boot words.
    access_chk("clobber128", 1'b1, 2'b10, 1'b0, 32'd128, 32'h999, 32'h000000EF, 1'b0);
    access_chk("read128", 1'b0, 2'b10, 1'b0, 32'd128, 32'h0, 32'h999, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h55555555;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort.ready", {31'd0, ready}, 32'd0);
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.dout", dout, 32'h0);
    rst = 1'b0;
    rcount = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ready) rcount++;
    end
    chk("abort.no_ready", 32'(rcount), 32'd0);
    access_chk("abort.old", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0);
    access_chk("repre128", 1'b0, 2'b10, 1'b0, 32'd128, 32'h0, 32'd2, 1'b0);
    access_chk("repre132", 1'b0, 2'b10, 1'b0, 32'd132, 32'h0, 32'd0, 1'b0);
    access_chk("repre136", 1'b0, 2'b10, 1'b0, 32'd136, 32'h0, 32'd64, 1'b0);
    access_chk("repre140", 1'b0, 2'b10, 1'b0, 32'd140, 32'h0, 32'd4, 1'b0);

    // LATENCY=4 with req held high: one acceptance every 6 cycles.
    chk("l4.reset_dout", dout4, 32'h0);
    chk("l4.reset_busy", {31'd0, busy4}, 32'd0);
    @(negedge clk);
    req4 = 1'b1;
    rcount = 0; bcount = 0; first_r = -1; last_r = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ready4) begin
        rcount++;
        chk($sformatf("l4.dout@%0d", k), dout4, 32'd2);
        if (first_r < 0) first_r = k;
        else chk($sformatf("l4.interval@%0d", k), 32'(k - last_r), 32'd6);
        last_r = k;
      end
      if (busy4) bcount++;
    end
    req4 = 1'b0;
    chk("l4.first_ready", 32'(first_r), 32'd4);
    chk("l4.ready_count", 32'(rcount), 32'd5);
    chk("l4.busy_cycles", 32'(bcount), 32'd25);

    repeat (8) @(negedge clk);
    chk("l4.idle", {31'd0, busy4}, 32'd0);
    req4 = 1'b1;
    rcount = 0; bcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ready4) rcount++;
      if (busy4) bcount++;
      req4 = (k == 1 || k == 2);
    end
    chk("l4.pulse_ready_count", 32'(rcount), 32'd1);
    chk("l4.pulse_busy_cycles", 32'(bcount), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
